// File: rtl/time_counter_pkg.sv
// Shared constants and BCD helpers for the time-of-day counter.
// Limits are stored as plain integers; BCD encodings are derived where needed.
package time_counter_pkg;

  localparam int TICKS_PER_SEC_DEFAULT = 100;
  localparam int PRESC_W               = 10;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Two packed BCD digits, {tens, ones}.
  typedef logic [7:0] bcd2_t;

  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic is_bcd2(input bcd2_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from modulus-1 to 00.
// carry flags the increment that performs the wrap, so counters can be chained.
module bcd_mod_counter
  import time_counter_pkg::*;
#(
  parameter int modulus = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  localparam bcd2_t MAX_BCD = to_bcd2(modulus - 1);

  bcd2_t next_value;
  logic  in_range;

  // BCD ordering matches binary ordering, so a plain compare bounds the range.
  assign in_range = is_bcd2(value) && (value <= MAX_BCD);

  always_comb begin
    // NOTE: default first so every path assigns next_value; no latch is inferred.
    next_value = value;
    if (!in_range) begin
      next_value = '0;
    end else if (inc) begin
      if (value == MAX_BCD) begin
        next_value = '0;
      end else if (value[3:0] == 4'd9) begin
        next_value = {value[7:4] + 4'd1, 4'd0};
      end else begin
        next_value = {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else begin
      value <= next_value;
    end
  end

  assign carry = inc & (value == MAX_BCD);

endmodule

// File: rtl/time_counter.sv
// HH:MM:SS BCD clock advanced by tick_in rising edges, with a set mode for
// manual minute/hour adjustment while run is low.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       sec_pulse
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic               tick_d, min_d, hour_d;
  logic               tick_edge, min_edge, hour_edge;
  logic [PRESC_W-1:0] presc;
  logic               sec_adv;
  logic               sec_carry, min_carry, hour_carry;
  logic               min_inc, hour_inc;

  // Delayed copies come out of reset high so a level already asserted
  // at reset release is not mistaken for a fresh edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_d <= 1'b1;
      min_d  <= 1'b1;
      hour_d <= 1'b1;
    end else begin
      tick_d <= tick_in;
      min_d  <= inc_min;
      hour_d <= inc_hour;
    end
  end

  assign tick_edge = tick_in  & ~tick_d;
  assign min_edge  = inc_min  & ~min_d;
  assign hour_edge = inc_hour & ~hour_d;

  assign sec_adv = run & tick_edge & (presc == PRESC_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (run && tick_edge) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= sec_adv;
    end
  end

  // In set mode the buttons drive the counters directly and carries are cut.
  assign min_inc  = run ? sec_carry : min_edge;
  assign hour_inc = run ? min_carry : hour_edge;

  bcd_mod_counter #(.modulus(SEC_MAX + 1)) u_sec (
    .clock (clock),
    .reset (reset),
    .inc   (sec_adv),
    .value (sec_bcd),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.modulus(MIN_MAX + 1)) u_min (
    .clock (clock),
    .reset (reset),
    .inc   (min_inc),
    .value (min_bcd),
    .carry (min_carry)
  );

  bcd_mod_counter #(.modulus(HOUR_MAX + 1)) u_hour (
    .clock (clock),
    .reset (reset),
    .inc   (hour_inc),
    .value (hour_bcd),
    .carry (hour_carry)
  );

  // The hour wrap goes nowhere; its only consequence is the return to 00.
  a_hour_wrap : assert property (@(posedge clock) disable iff (reset)
    hour_carry |=> (hour_bcd == 8'h00));

endmodule

// File: tb/tb_time_counter.sv
// Scoreboarded bench for time_counter: stimulus queues every expected output
// change, a negedge monitor pops one entry per observed change.
module tb_time_counter;

  localparam int TPS = 4;

  logic       clock = 1'b0;
  logic       reset, tick_in, run, inc_min, inc_hour;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       sec_pulse;

  time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (tick_in),
    .run       (run),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .sec_pulse (sec_pulse)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       p;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev_s, cur_s;
  bit    mon_en = 1'b0;
  int    total = 0;
  int    bad   = 0;
  int    mh = 0, mm = 0, ms = 0, mp = 0;

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check(name, 32'({hour_bcd, min_bcd, sec_bcd}), 32'({bcd(h), bcd(m), bcd(s)}));
  endtask

  task automatic push(input logic p);
    snap_t e;
    e.h = bcd(mh);
    e.m = bcd(mm);
    e.s = bcd(ms);
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic advance_sec();
    ms++;
    if (ms == 60) begin
      ms = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
    push(1'b1);
    push(1'b0);
  endtask

  // One tick_in rising edge; it is registered on the second posedge.
  task automatic tick();
    @(posedge clock); #1 tick_in = 1'b1;
    if (run) begin
      mp++;
      if (mp == TPS) begin
        mp = 0;
        advance_sec();
      end
    end
    @(posedge clock); #1 tick_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit do_min, input bit do_hour);
    @(posedge clock); #1;
    inc_min  = do_min;
    inc_hour = do_hour;
    if (!run) begin
      if (do_min)  mm = (mm + 1) % 60;
      if (do_hour) mh = (mh + 1) % 24;
      push(1'b0);
    end
    @(posedge clock); #1;
    inc_min  = 1'b0;
    inc_hour = 1'b0;
  endtask

  task automatic model_reset();
    if (mh != 0 || mm != 0 || ms != 0) begin
      mh = 0; mm = 0; ms = 0;
      push(1'b0);
    end
    mp = 0;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      cur_s = {hour_bcd, min_bcd, sec_bcd, sec_pulse};
      if (cur_s !== prev_s) begin
        if (exp_q.size() == 0) check("sb_unexpected", 32'(cur_s), 32'(prev_s));
        else                   check("sb_change", 32'(cur_s), 32'(exp_q.pop_front()));
        prev_s = cur_s;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tick_in = 1'b0; run = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_time("reset_time", 0, 0, 0);
    check("reset_pulse", 32'(sec_pulse), 32'd0);
    reset  = 1'b0;
    prev_s = {hour_bcd, min_bcd, sec_bcd, sec_pulse};
    mon_en = 1'b1;

    // First second: advance lands on the 4th edge, strobe follows for one cycle.
    run = 1'b1;
    ticks(TPS - 1);
    check_time("before_first_sec", 0, 0, 0);
    tick();
    check_time("first_sec", 0, 0, 1);
    check("first_pulse", 32'(sec_pulse), 32'd1);
    @(posedge clock); #1;
    check("pulse_one_cycle", 32'(sec_pulse), 32'd0);

    // 00:00:59 -> 00:01:00 in a single step.
    ticks(58 * TPS);
    check_time("at_59s", 0, 0, 59);
    ticks(TPS - 1);
    check_time("still_59s", 0, 0, 59);
    tick();
    check_time("sec_to_min_carry", 0, 1, 0);
    check("carry_pulse", 32'(sec_pulse), 32'd1);

    // Buttons while running are ignored and leave no stale edge behind.
    @(posedge clock); #1 inc_min = 1'b1; inc_hour = 1'b1;
    repeat (3) @(posedge clock);
    #1 run = 1'b0;
    repeat (3) @(posedge clock);
    #1 inc_min = 1'b0; inc_hour = 1'b0;
    @(posedge clock); #1;
    check_time("no_stale_edge", 0, 1, 0);

    // Set mode: minute wrap without hour carry, ticks discarded, joint press.
    repeat (58) press(1'b1, 1'b0);
    check_time("set_min_59", 0, 59, 0);
    press(1'b1, 1'b0);
    check_time("set_min_wrap", 0, 0, 0);
    ticks(2 * TPS);
    check_time("ticks_ignored", 0, 0, 0);
    repeat (9)  press(1'b0, 1'b1);
    repeat (12) press(1'b1, 1'b0);
    check_time("set_0912", 9, 12, 0);
    press(1'b1, 1'b1);
    check_time("joint_press", 10, 13, 0);

    // Prescaler keeps its count across run toggling.
    run = 1'b1;
    ticks(2);
    run = 1'b0;
    ticks(3);
    run = 1'b1;
    ticks(1);
    check_time("presc_held", 10, 13, 0);
    tick();
    check_time("presc_resumed", 10, 13, 1);

    // 23:59:59 -> 00:00:00 on one edge.
    run = 1'b0;
    repeat (13) press(1'b0, 1'b1);
    repeat (46) press(1'b1, 1'b0);
    check_time("set_2359", 23, 59, 1);
    run = 1'b1;
    ticks(58 * TPS);
    check_time("at_235959", 23, 59, 59);
    ticks(TPS - 1);
    check_time("still_235959", 23, 59, 59);
    tick();
    check_time("day_wrap", 0, 0, 0);
    check("day_wrap_pulse", 32'(sec_pulse), 32'd1);
    @(posedge clock); #1;
    check("day_wrap_pulse_end", 32'(sec_pulse), 32'd0);

    // tick_in high across reset release is not an edge.
    ticks(TPS);
    @(posedge clock); #1;
    tick_in = 1'b1; reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_time("held_tick_no_count", 0, 0, 0);
    tick_in = 1'b0;
    ticks(TPS - 1);
    check_time("held_tick_3_edges", 0, 0, 0);
    tick();
    check_time("held_tick_4th_edge", 0, 0, 1);

    // Reset at prescaler=2 clears everything; a full 4 edges are needed again.
    @(posedge clock); #1;
    ticks(2);
    @(posedge clock); #1 reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    check_time("reset_mid_count", 0, 0, 0);
    check("reset_mid_pulse", 32'(sec_pulse), 32'd0);
    reset = 1'b0;
    ticks(TPS - 1);
    check_time("restart_3_edges", 0, 0, 0);
    tick();
    check_time("restart_4th_edge", 0, 0, 1);

    // Reset beats a set-mode press in the same cycle.
    @(posedge clock); #1 run = 1'b0;
    repeat (3) press(1'b1, 1'b0);
    check_time("set_before_reset", 0, 3, 1);
    @(posedge clock); #1 inc_min = 1'b1; reset = 1'b1;
    model_reset();
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_time("reset_beats_press", 0, 0, 0);
    inc_min = 1'b0;

    repeat (4) @(posedge clock);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100, is the number of tick_in rising edges per second (range 2..1023).
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick_in  input  1  square wave from the frequency divider, a register output in the clock domain; only its rising edges count.
REQ-005 run  input  1  1 = timekeeping; 0 = set mode, time frozen.
REQ-006 inc_min  input  1  debounced set button level; each rising edge is one minute increment.
REQ-007 inc_hour  input  1  debounced set button level; each rising edge is one hour increment.
REQ-008 sec_bcd  output  8  seconds, two BCD digits {tens, ones}, 00..59.
REQ-009 min_bcd  output  8  minutes, two BCD digits, 00..59.
REQ-010 hour_bcd  output  8  hours, two BCD digits, 00..23.
REQ-011 sec_pulse  output  1  one-cycle strobe, high in the cycle after the seconds value advances.

Function
REQ-012 Edge detect: each of tick_in, inc_min and inc_hour SHALL have a one-register delayed copy; edge = input & ~delayed copy; no further synchronisation.
REQ-013 Prescaler: a 10-bit counter, 0..TICKS_PER_SEC-1, SHALL increment on each tick edge while run=1, wrapping to 0 on the edge that finds it at TICKS_PER_SEC-1; that wrap edge is a second-advance.
REQ-014 Second-advance: seconds +1 BCD; 09->10 style digit carry; 59->00 SHALL carry into minutes.
REQ-015 Minute carry: minutes +1; 59->00 SHALL carry into hours.
REQ-016 Hour carry: hours +1; 23->00 wraps, with no further carry.
REQ-017 Latency: all counter outputs SHALL change on the same clock edge that registers the qualifying edge (registered outputs, zero extra pipeline); sec_pulse is high for exactly the following cycle.
REQ-018 run=0: prescaler, seconds and sec_pulse SHALL hold; tick edges are discarded, not queued.
REQ-019 inc_min edge with run=0: minutes +1 mod 60, with no carry to hours; seconds and prescaler unchanged.
REQ-020 inc_hour edge with run=0: hours +1 mod 24.
REQ-021 inc_min and inc_hour edges in the same cycle with run=0: both apply independently.
REQ-022 run=1: inc_min and inc_hour SHALL be ignored; their delayed copies still track, so there is no stale edge on return to run=0.
REQ-023 run toggling SHALL NOT reset the prescaler; counting resumes from the held value.
REQ-024 Outputs SHALL never present a non-BCD digit or an out-of-range value.

Reset
REQ-025 The state on the clock edge with reset=1 SHALL be:
- sec_bcd, min_bcd, hour_bcd = 8'h00.
- prescaler = 0.
- sec_pulse = 0.
- All three delayed copies = 1, so an input already high at reset release does not produce an edge.
REQ-026 Reset SHALL take priority over every other event in the same cycle, including mid-count and mid-set-mode.

Structure
REQ-027 A shared package SHALL hold TICKS_PER_SEC default, the BCD limits (59, 23) and the prescaler width constant.
REQ-028 One sub-module, bcd_mod_counter, SHALL implement the two-digit BCD counter:
- Parameter: modulus.
- Ports: clock, reset, inc, value[7:0], carry.
- Instantiated three times.
- Carry is combinational: inc & value==max.

Verification
REQ-029 Run the bench with TICKS_PER_SEC=4.
REQ-030 Reset, run=1, 4 tick edges -> sec_bcd 00->01 on the 4th edge; sec_pulse high exactly 1 cycle after that edge.
REQ-031 Preload 00:00:59 via set mode plus ticks, then 4 tick edges -> 00:01:00 on the same edge, with no intermediate value visible.
REQ-032 Reach 23:59:59, then 4 tick edges -> 00:00:00 on one edge; sec_pulse high one cycle.
REQ-033 run=0 at min 59, inc_min edge -> min 00, hour unchanged; inc_min and inc_hour in the same cycle at 09:12 -> 10:13; tick edges ignored.
REQ-034 tick_in held high across reset release -> no count until the next 0->1; reset asserted at prescaler=2 -> all outputs 00 next cycle, and the count restarts with a full 4 edges.
